icu_sequencer: RTL and testbench
================================

Name: icu_sequencer

Overview:
- Program sequencer for the 1-bit ICU: owns the program counter and fetches instruction words from an asynchronous-read program memory.
- Splits each word into a 4-bit opcode (instruction_t) and an operand/I-O address, and presents both to the ICU.
- Redirects the PC on the ICU's jmp/rtn strobes and runs an IDLE/RUN/HALTED run-control FSM that gates the ICU reset.
- Sits between program ROM, I/O address decoder and ICU at the top of the processor.

Parameters:
ADDR_W, 8, width of PC and of the operand field (program address and I/O address)
STACK_DEPTH, 4, return-stack entries (used only with ICU_CALL_STACK_EN)
RESET_PC, 0, PC value on reset and in IDLE
HALT_ON_NOPF, 1, when 1 an executed NOPF halts the sequencer

Ports:
clk  in  1  system clock; all sequencer state updates on posedge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: IDLE->RUN or HALTED->RUN
prog_addr  out  ADDR_W  program memory address (= registered PC)
prog_data  in  4+ADDR_W  program word; [ADDR_W+3:ADDR_W]=opcode, [ADDR_W-1:0]=operand
instruction  out  4  opcode to ICU (instruction_t)
operand  out  ADDR_W  operand field: I/O address and jump target
icu_rst  out  1  reset to ICU
jmp  in  1  ICU jump strobe
rtn  in  1  ICU return strobe
flag_f  in  1  ICU NOPF flag
flag_o  in  1  ICU NOPO flag; exported unchanged, no PC effect
running  out  1  high in RUN
stack_err  out  1  sticky stack overflow/underflow

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, pc=RESET_PC, stack emptied, stack_err=0.
  - Outputs: prog_addr=RESET_PC, icu_rst=1, running=0.
- Reset mid-operation behaves identically; no partial PC update.
- Fetch is combinational from the PC: instruction/operand = prog_data slices in RUN. The ICU latches the opcode at negedge, so its jmp/rtn/flag_f are valid at the following posedge, in the same cycle the PC still addresses that instruction. There is no delay slot.
- IDLE:
  - icu_rst=1; instruction forced to NOPO (4'h0); pc held at RESET_PC.
  - start -> RUN. icu_rst deasserts from that posedge; the first fetch is RESET_PC.
- RUN: icu_rst=0. Next PC at each posedge, highest priority first:
  1. rtn (feature on): pc <= pop.
  2. jmp: pc <= operand. With the feature on, also push pc+1.
  3. flag_f and HALT_ON_NOPF=1: pc <= pc+1, state <= HALTED.
  4. Otherwise pc <= pc+1.
- start is ignored in RUN.
- The ICU itself skips the first instruction after a RTN. The word at the return address (call site + 1) is therefore never executed; programs place a NOP there.
- HALTED:
  - pc frozen; instruction forced to NOPO; icu_rst=0, so ICU RR/IEN/OEN are preserved.
  - flag_o pulses from the forced NOPO are ignored.
  - start -> RUN, resuming at the frozen pc.
- PC arithmetic is modulo 2^ADDR_W: pc+1 from all-ones wraps to 0; a push of all-ones+1 stores 0.
- jmp and rtn together cannot occur from one opcode; if both are seen, rtn wins and no push happens.

Optional Feature:
- Macro: ICU_CALL_STACK_EN.
- Defined:
  - STACK_DEPTH-entry LIFO. jmp pushes the return address pc+1; rtn pops into the PC.
  - Push when full: push dropped, jump still taken, stack_err<=1.
  - Pop when empty: pc <= pc+1, stack_err<=1.
  - Simultaneous push/pop cannot occur (rtn wins).
  - stack_err is cleared only by rst.
- Undefined:
  - No stack; jmp loads operand only; rtn has no PC effect (pc+1).
  - stack_err tied 0.

Decomposition:
- The shared instructions package gains:
  - OPCODE_W=4;
  - typedef seq_state_t {SEQ_IDLE, SEQ_RUN, SEQ_HALTED};
  - the NOPO encoding constant used for forced fetches.
- Sub-module: icu_return_stack, a parameterised LIFO with push/pop/full/empty/top, instantiated only under ICU_CALL_STACK_EN.

Test Plan:
- Reset/start: rst=1 -> prog_addr=0x00, icu_rst=1, running=0, instruction=NOPO. Then start pulse -> icu_rst=0 and prog_addr 0x00, 0x01, 0x02 on successive cycles.
- Jump: JMP with operand 0x20 at 0x05 -> prog_addr sequence 0x05, 0x20, 0x21.
- Call/return (feature on): JMP 0x40 at 0x05, RTN at 0x42 -> prog_addr 0x05, 0x40, 0x41, 0x42, 0x06. The ICU skips 0x06; the stack is empty afterwards with stack_err=0.
- Stack overflow/underflow (feature on, STACK_DEPTH=4):
  - 5 nested JMPs without RTN -> stack_err=1 after the 5th, which still jumps.
  - After rst, a RTN on an empty stack -> stack_err=1 and the PC increments.
- Halt: NOPF at 0x10, HALT_ON_NOPF=1 -> running=0, prog_addr holds 0x11 for 5 cycles, instruction=NOPO, ICU RR unchanged. Then start -> prog_addr 0x11, 0x12.
- Wrap/reset mid-run: ADDR_W=8, straight code at 0xFE -> prog_addr 0xFE, 0xFF, 0x00. Then rst asserted in RUN -> next posedge prog_addr=0x00, icu_rst=1, running=0.

Source files
------------

// File: rtl/icu_sequencer_pkg.sv
// Shared definitions for the 1-bit ICU program sequencer: opcode encoding,
// run-control states and the opcode forced onto the ICU while not running.
package icu_sequencer_pkg;

  localparam int unsigned OPCODE_W = 4;

  // MC14500-style opcode map.
  typedef enum logic [OPCODE_W-1:0] {
    OP_NOPO = 4'h0,
    OP_LD   = 4'h1,
    OP_LDC  = 4'h2,
    OP_AND  = 4'h3,
    OP_ANDC = 4'h4,
    OP_OR   = 4'h5,
    OP_ORC  = 4'h6,
    OP_XNOR = 4'h7,
    OP_STO  = 4'h8,
    OP_STOC = 4'h9,
    OP_IEN  = 4'hA,
    OP_OEN  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RTN  = 4'hD,
    OP_SKZ  = 4'hE,
    OP_NOPF = 4'hF
  } instruction_t;

  // Opcode presented to the ICU whenever the sequencer is not in RUN.
  localparam instruction_t NOPO = OP_NOPO;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_HALTED
  } seq_state_t;

endpackage

// File: rtl/icu_sequencer_if.sv
// Bundle of run-control, program-memory and ICU-side signals of the sequencer.
// master: the sequencer; slave: the surrounding processor (ROM, ICU, control).
interface icu_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  import icu_sequencer_pkg::*;

  logic                       start;
  logic [ADDR_W-1:0]          prog_addr;
  logic [OPCODE_W+ADDR_W-1:0] prog_data;
  instruction_t               instruction;
  logic [ADDR_W-1:0]          operand;
  logic                       icu_rst;
  logic                       jmp;
  logic                       rtn;
  logic                       flag_f;
  logic                       flag_o;
  logic                       running;
  logic                       stack_err;

  modport master (
    input  start, prog_data, jmp, rtn, flag_f, flag_o,
    output prog_addr, instruction, operand, icu_rst, running, stack_err
  );

  modport slave (
    output start, prog_data, jmp, rtn, flag_f, flag_o,
    input  prog_addr, instruction, operand, icu_rst, running, stack_err
  );

endinterface

// File: rtl/icu_return_stack.sv
// Return-address LIFO for JMP/RTN subroutine calls. Only compiled when
// ICU_CALL_STACK_EN is defined; the sequencer instantiates it in that build.
`ifdef ICU_CALL_STACK_EN
module icu_return_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] top
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx = IDX_W'(cnt_q);
  assign rd_idx = IDX_W'(cnt_q - CNT_W'(1));
  assign full   = (cnt_q == CNT_W'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign top    = mem_q[rd_idx];

  // Occupancy count; pop has priority so a simultaneous request never pushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (push && !full) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Entry storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (push && !full && !pop) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule
`endif

// File: rtl/icu_sequencer.sv
// Program sequencer for the 1-bit ICU: owns the PC, fetches from an
// asynchronous program memory, follows the ICU's jmp/rtn strobes and runs the
// IDLE/RUN/HALTED run-control FSM that gates the ICU reset.
// Optional return stack: define ICU_CALL_STACK_EN.
module icu_sequencer
  import icu_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 8,
  parameter int unsigned       STACK_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter bit                HALT_ON_NOPF = 1'b1
) (
  input logic             clk,
  input logic             rst,
  icu_sequencer_if.master bus
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] operand;
  logic              unused_in;

  assign pc_inc  = pc_q + ADDR_W'(1);
  assign operand = bus.prog_data[ADDR_W-1:0];

  // flag_o is exported to the rest of the processor and has no PC effect.
  assign unused_in = bus.flag_o ^ (STACK_DEPTH != 0);

`ifdef ICU_CALL_STACK_EN
  logic              stk_push;
  logic              stk_pop;
  logic              stk_full;
  logic              stk_empty;
  logic [ADDR_W-1:0] stk_top;
  logic              err_set;
  logic              stack_err_q;

  icu_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_return_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .full  (stk_full),
    .empty (stk_empty),
    .top   (stk_top)
  );

  // Sticky stack fault; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stack_err_q <= 1'b0;
    end else if (err_set) begin
      stack_err_q <= 1'b1;
    end
  end

  assign bus.stack_err = stack_err_q;
`else
  assign bus.stack_err = 1'b0;
`endif

  // Run-control state and program counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state and next PC; strobes refer to the instruction at pc_q.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef ICU_CALL_STACK_EN
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    err_set  = 1'b0;
`endif
    unique case (state_q)
      SEQ_IDLE: begin
        pc_d = RESET_PC;
        if (bus.start) state_d = SEQ_RUN;
      end
      SEQ_RUN: begin
        if (bus.rtn) begin
`ifdef ICU_CALL_STACK_EN
          if (stk_empty) begin
            pc_d    = pc_inc;
            err_set = 1'b1;
          end else begin
            pc_d    = stk_top;
            stk_pop = 1'b1;
          end
`else
          pc_d = pc_inc;
`endif
        end else if (bus.jmp) begin
          pc_d = operand;
`ifdef ICU_CALL_STACK_EN
          // A full stack drops the return address but the jump is still taken.
          if (stk_full) err_set  = 1'b1;
          else          stk_push = 1'b1;
`endif
        end else if (bus.flag_f && HALT_ON_NOPF) begin
          pc_d    = pc_inc;
          state_d = SEQ_HALTED;
        end else begin
          pc_d = pc_inc;
        end
      end
      SEQ_HALTED: begin
        if (bus.start) state_d = SEQ_RUN;
      end
      default: begin
        state_d = SEQ_IDLE;
        pc_d    = RESET_PC;
      end
    endcase
  end

  // Fetch path: outside RUN the ICU sees NOPO so it cannot act on stale words.
  always_comb begin
    bus.prog_addr   = pc_q;
    bus.operand     = operand;
    bus.icu_rst     = (state_q == SEQ_IDLE);
    bus.running     = (state_q == SEQ_RUN);
    bus.instruction = NOPO;
    if (state_q == SEQ_RUN) begin
      bus.instruction = instruction_t'(bus.prog_data[ADDR_W+OPCODE_W-1:ADDR_W]);
    end
  end

endmodule

// File: tb/tb_icu_sequencer.sv
// Self-checking bench for icu_sequencer: directed scenarios followed by
// random programs, all compared each cycle against a behavioural model.
module tb_icu_sequencer;

  localparam logic [3:0] OPC_NOPO = 4'h0;
  localparam logic [3:0] OPC_LD   = 4'h1;
  localparam logic [3:0] OPC_JMP  = 4'hC;
  localparam logic [3:0] OPC_RTN  = 4'hD;
  localparam logic [3:0] OPC_NOPF = 4'hF;
  localparam int DEPTH = 4;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk;
  logic rst;
  logic [11:0] mem [256];

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int m_pc;
  int m_mode;
  int m_stk[$];
  bit m_err;

  icu_sequencer_if #(.ADDR_W(8)) bus ();

  icu_sequencer #(
    .ADDR_W       (8),
    .STACK_DEPTH  (DEPTH),
    .RESET_PC     (8'h00),
    .HALT_ON_NOPF (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Program ROM and a minimal ICU: strobes decoded straight from the opcode.
  assign bus.prog_data = mem[bus.prog_addr];
  assign bus.jmp       = (bus.instruction == OPC_JMP);
  assign bus.rtn       = (bus.instruction == OPC_RTN);
  assign bus.flag_f    = (bus.instruction == OPC_NOPF);
  assign bus.flag_o    = (bus.instruction == OPC_NOPO);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    logic [3:0] op;
    int arg;
    if (rst) begin
      m_pc = 0;
      m_mode = M_IDLE;
      m_stk.delete();
      m_err = 1'b0;
    end else if (m_mode == M_IDLE) begin
      m_pc = 0;
      if (bus.start) m_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      if (bus.start) m_mode = M_RUN;
    end else begin
      op  = mem[m_pc][11:8];
      arg = int'(mem[m_pc][7:0]);
      if (op == OPC_RTN) begin
`ifdef ICU_CALL_STACK_EN
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_pc = (m_pc + 1) % 256;
          m_err = 1'b1;
        end
`else
        m_pc = (m_pc + 1) % 256;
`endif
      end else if (op == OPC_JMP) begin
`ifdef ICU_CALL_STACK_EN
        if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % 256);
        else m_err = 1'b1;
`endif
        m_pc = arg;
      end else if (op == OPC_NOPF) begin
        m_pc = (m_pc + 1) % 256;
        m_mode = M_HALT;
      end else begin
        m_pc = (m_pc + 1) % 256;
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] exp_op;
    exp_op = (m_mode == M_RUN) ? mem[m_pc][11:8] : OPC_NOPO;
    chk("prog_addr", 32'(bus.prog_addr), 32'(m_pc));
    chk("running", 32'(bus.running), 32'(m_mode == M_RUN));
    chk("icu_rst", 32'(bus.icu_rst), 32'(m_mode == M_IDLE));
    chk("instruction", 32'(bus.instruction), 32'(exp_op));
    chk("stack_err", 32'(bus.stack_err), 32'(m_err));
    if (m_mode == M_RUN) chk("operand", 32'(bus.operand), 32'(mem[m_pc][7:0]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fill_straight();
    for (int i = 0; i < 256; i++) mem[i] = {OPC_LD, 8'(i)};
  endtask

  task automatic put(input int addr, input logic [3:0] op, input logic [7:0] arg);
    mem[addr] = {op, arg};
  endtask

  task automatic reset_and_start();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;

    // Reset state, start, straight-line fetch and a plain jump.
    fill_straight();
    put(8'h05, OPC_JMP, 8'h20);
    tick();
    chk("rst_prog_addr", 32'(bus.prog_addr), 32'h00);
    chk("rst_icu_rst", 32'(bus.icu_rst), 32'h1);
    chk("rst_running", 32'(bus.running), 32'h0);
    chk("rst_instr", 32'(bus.instruction), 32'(OPC_NOPO));
    rst = 1'b0;
    tick();
    chk("idle_icu_rst", 32'(bus.icu_rst), 32'h1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_addr0", 32'(bus.prog_addr), 32'h00);
    chk("start_icu_rst", 32'(bus.icu_rst), 32'h0);
    tick();
    chk("seq_addr1", 32'(bus.prog_addr), 32'h01);
    tick();
    chk("seq_addr2", 32'(bus.prog_addr), 32'h02);
    ticks(3);
    chk("jmp_site", 32'(bus.prog_addr), 32'h05);
    tick();
    chk("jmp_target", 32'(bus.prog_addr), 32'h20);
    tick();
    chk("jmp_after", 32'(bus.prog_addr), 32'h21);

    // Call and return.
    fill_straight();
    put(8'h05, OPC_JMP, 8'h40);
    put(8'h42, OPC_RTN, 8'h00);
    reset_and_start();
    ticks(5);
    chk("call_site", 32'(bus.prog_addr), 32'h05);
    ticks(3);
    chk("call_body", 32'(bus.prog_addr), 32'h42);
    tick();
`ifdef ICU_CALL_STACK_EN
    chk("ret_addr", 32'(bus.prog_addr), 32'h06);
`else
    chk("ret_addr", 32'(bus.prog_addr), 32'h43);
`endif
    chk("ret_err", 32'(bus.stack_err), 32'h0);

    // Five nested jumps: the fifth overflows a four-entry stack.
    fill_straight();
    put(8'h00, OPC_JMP, 8'h10);
    put(8'h10, OPC_JMP, 8'h20);
    put(8'h20, OPC_JMP, 8'h30);
    put(8'h30, OPC_JMP, 8'h40);
    put(8'h40, OPC_JMP, 8'h50);
    reset_and_start();
    ticks(4);
    chk("ovf_before", 32'(bus.stack_err), 32'h0);
    tick();
    chk("ovf_jump", 32'(bus.prog_addr), 32'h50);
`ifdef ICU_CALL_STACK_EN
    chk("ovf_err", 32'(bus.stack_err), 32'h1);
`else
    chk("ovf_err", 32'(bus.stack_err), 32'h0);
`endif

    // Return on an empty stack.
    fill_straight();
    put(8'h00, OPC_RTN, 8'h00);
    reset_and_start();
    chk("unf_clear", 32'(bus.stack_err), 32'h0);
    tick();
    chk("unf_pc", 32'(bus.prog_addr), 32'h01);
`ifdef ICU_CALL_STACK_EN
    chk("unf_err", 32'(bus.stack_err), 32'h1);
`endif

    // Halt on NOPF, hold, then resume.
    fill_straight();
    put(8'h10, OPC_NOPF, 8'h00);
    reset_and_start();
    ticks(17);
    chk("halt_running", 32'(bus.running), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_hold", 32'(bus.prog_addr), 32'h11);
      chk("halt_instr", 32'(bus.instruction), 32'(OPC_NOPO));
      chk("halt_icu_rst", 32'(bus.icu_rst), 32'h0);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("resume_addr", 32'(bus.prog_addr), 32'h11);
    chk("resume_running", 32'(bus.running), 32'h1);
    tick();
    chk("resume_next", 32'(bus.prog_addr), 32'h12);

    // PC wrap and reset in the middle of a run.
    fill_straight();
    put(8'h00, OPC_JMP, 8'hFE);
    reset_and_start();
    tick();
    chk("wrap_fe", 32'(bus.prog_addr), 32'hFE);
    tick();
    chk("wrap_ff", 32'(bus.prog_addr), 32'hFF);
    tick();
    chk("wrap_00", 32'(bus.prog_addr), 32'h00);
    ticks(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_addr", 32'(bus.prog_addr), 32'h00);
    chk("midrst_icu_rst", 32'(bus.icu_rst), 32'h1);
    chk("midrst_running", 32'(bus.running), 32'h0);

    // Random programs with random start pulses and occasional resets.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 256; i++) begin
        int r;
        logic [3:0] op;
        r = $urandom_range(0, 99);
        if (r < 6)       op = OPC_JMP;
        else if (r < 12) op = OPC_RTN;
        else if (r < 15) op = OPC_NOPF;
        else             op = 4'($urandom_range(0, 11));
        mem[i] = {op, 8'($urandom_range(0, 255))};
      end
      reset_and_start();
      for (int c = 0; c < 500; c++) begin
        bus.start = ($urandom_range(0, 15) == 0);
        rst = ($urandom_range(0, 199) == 0);
        tick();
      end
      bus.start = 1'b0;
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
